// File: rtl/ccr_unit.sv
// Condition-code register stage with 68000 branch-condition evaluation and a DBcc loop counter.
// Build option: define CCR_FORWARD_EN so same-cycle evaluations see the next-state CCR.
module ccr_unit #(
  parameter int bits = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            alu_valid,
  input  logic            alu_c,
  input  logic            alu_z,
  input  logic            alu_v,
  input  logic            alu_n,
  input  logic [4:0]      upd_mask,
  input  logic            z_sticky,
  input  logic            wr_en,
  input  logic [1:0]      wr_op,
  input  logic [4:0]      wr_data,
  input  logic [3:0]      cond,
  input  logic            cond_valid,
  output logic            cond_true,
  output logic            cond_done,
  input  logic            db_load,
  input  logic [bits-1:0] db_init,
  input  logic            db_step,
  output logic            db_branch,
  output logic            db_exit,
  output logic [bits-1:0] db_count,
  output logic [4:0]      ccr
);

  // Flag vector is NZVC: [3]=N [2]=Z [1]=V [0]=C.
  function automatic logic cond_eval(input logic [3:0] sel, input logic [3:0] f);
    logic n, z, v, c;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (sel)
      4'h0:    cond_eval = 1'b1;
      4'h1:    cond_eval = 1'b0;
      4'h2:    cond_eval = !c && !z;
      4'h3:    cond_eval = c || z;
      4'h4:    cond_eval = !c;
      4'h5:    cond_eval = c;
      4'h6:    cond_eval = !z;
      4'h7:    cond_eval = z;
      4'h8:    cond_eval = !v;
      4'h9:    cond_eval = v;
      4'hA:    cond_eval = !n;
      4'hB:    cond_eval = n;
      4'hC:    cond_eval = (n == v);
      4'hD:    cond_eval = (n != v);
      4'hE:    cond_eval = !z && (n == v);
      default: cond_eval = z || (n != v);
    endcase
  endfunction

  logic [4:0]      ccr_q, ccr_d;
  logic            cond_true_q, cond_true_d;
  logic            cond_done_q, cond_done_d;
  logic [bits-1:0] db_count_q, db_count_d;
  logic            db_branch_q, db_branch_d;
  logic            db_exit_q, db_exit_d;
  logic [3:0]      eval_nzvc;
  logic            hit;
  logic [bits-1:0] dec;

  always_comb begin
    ccr_d = ccr_q;
    if (wr_en) begin
      case (wr_op)
        2'b00:   ccr_d = wr_data;
        2'b01:   ccr_d = wr_data & ccr_q;
        2'b10:   ccr_d = wr_data | ccr_q;
        default: ccr_d = wr_data ^ ccr_q;
      endcase
    end else if (alu_valid) begin
      if (upd_mask[4]) ccr_d[4] = alu_c;
      if (upd_mask[3]) ccr_d[3] = alu_n;
      // Sticky Z lets multi-word ops clear Z but never set it.
      if (upd_mask[2]) ccr_d[2] = z_sticky ? (ccr_q[2] & alu_z) : alu_z;
      if (upd_mask[1]) ccr_d[1] = alu_v;
      if (upd_mask[0]) ccr_d[0] = alu_c;
    end
  end

`ifdef CCR_FORWARD_EN
  assign eval_nzvc = ccr_d[3:0];
`else
  assign eval_nzvc = ccr_q[3:0];
`endif

  assign hit = cond_eval(cond, eval_nzvc);
  assign dec = db_count_q - {{(bits-1){1'b0}}, 1'b1};

  always_comb begin
    cond_done_d = cond_valid;
    cond_true_d = cond_valid ? hit : cond_true_q;
    db_count_d  = db_count_q;
    db_branch_d = 1'b0;
    db_exit_d   = 1'b0;
    if (db_load) begin
      db_count_d = db_init;
    end else if (db_step) begin
      if (hit) begin
        db_exit_d = 1'b1;
      end else begin
        db_count_d  = dec;
        db_exit_d   = (dec == {bits{1'b1}});
        db_branch_d = (dec != {bits{1'b1}});
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ccr_q       <= '0;
      cond_true_q <= 1'b0;
      cond_done_q <= 1'b0;
      db_count_q  <= '0;
      db_branch_q <= 1'b0;
      db_exit_q   <= 1'b0;
    end else begin
      ccr_q       <= ccr_d;
      cond_true_q <= cond_true_d;
      cond_done_q <= cond_done_d;
      db_count_q  <= db_count_d;
      db_branch_q <= db_branch_d;
      db_exit_q   <= db_exit_d;
    end
  end

  assign ccr       = ccr_q;
  assign cond_true = cond_true_q;
  assign cond_done = cond_done_q;
  assign db_count  = db_count_q;
  assign db_branch = db_branch_q;
  assign db_exit   = db_exit_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Bench for ccr_unit: directed scenarios plus randomized traffic against a flag-level reference model.
module tb_ccr_unit;
  localparam int BITS = 16;
`ifdef CCR_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            alu_valid, alu_c, alu_z, alu_v, alu_n;
  logic [4:0]      upd_mask;
  logic            z_sticky, wr_en;
  logic [1:0]      wr_op;
  logic [4:0]      wr_data;
  logic [3:0]      cond;
  logic            cond_valid, cond_true, cond_done;
  logic            db_load, db_step, db_branch, db_exit;
  logic [BITS-1:0] db_init, db_count;
  logic [4:0]      ccr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: individual flags and an integer loop count.
  bit m_x, m_n, m_z, m_v, m_c;
  int m_cnt;
  bit e_done, e_true, e_branch, e_exit;

  ccr_unit #(.bits(BITS)) dut (
    .clk(clk), .reset(reset), .alu_valid(alu_valid), .alu_c(alu_c), .alu_z(alu_z),
    .alu_v(alu_v), .alu_n(alu_n), .upd_mask(upd_mask), .z_sticky(z_sticky), .wr_en(wr_en),
    .wr_op(wr_op), .wr_data(wr_data), .cond(cond), .cond_valid(cond_valid),
    .cond_true(cond_true), .cond_done(cond_done), .db_load(db_load), .db_init(db_init),
    .db_step(db_step), .db_branch(db_branch), .db_exit(db_exit), .db_count(db_count), .ccr(ccr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_cond(input int sel, input bit n, input bit z, input bit v, input bit c);
    case (sel)
      0: return 1;
      1: return 0;
      2: return !c && !z;
      3: return c || z;
      4: return !c;
      5: return c;
      6: return !z;
      7: return z;
      8: return !v;
      9: return v;
      10: return !n;
      11: return n;
      12: return n == v;
      13: return n != v;
      14: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction

  function automatic logic [4:0] m_pack();
    return {m_x, m_n, m_z, m_v, m_c};
  endfunction

  task automatic model_reset();
    {m_x, m_n, m_z, m_v, m_c} = 5'b0;
    m_cnt = 0;
    e_done = 0; e_true = 0; e_branch = 0; e_exit = 0;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    bit ox, on, oz, ov, oc, t;
    logic [4:0] w;
    ox = m_x; on = m_n; oz = m_z; ov = m_v; oc = m_c;
    if (wr_en) begin
      w = wr_data;
      case (wr_op)
        2'd0: {m_x, m_n, m_z, m_v, m_c} = w;
        2'd1: {m_x, m_n, m_z, m_v, m_c} = w & {ox, on, oz, ov, oc};
        2'd2: {m_x, m_n, m_z, m_v, m_c} = w | {ox, on, oz, ov, oc};
        default: {m_x, m_n, m_z, m_v, m_c} = w ^ {ox, on, oz, ov, oc};
      endcase
    end else if (alu_valid) begin
      if (upd_mask[4]) m_x = alu_c;
      if (upd_mask[3]) m_n = alu_n;
      if (upd_mask[2]) m_z = z_sticky ? (oz && alu_z) : alu_z;
      if (upd_mask[1]) m_v = alu_v;
      if (upd_mask[0]) m_c = alu_c;
    end
    if (FWD) t = ref_cond(int'(cond), m_n, m_z, m_v, m_c);
    else     t = ref_cond(int'(cond), on, oz, ov, oc);
    e_done = cond_valid;
    if (cond_valid) e_true = t;
    e_branch = 0; e_exit = 0;
    if (db_load) m_cnt = int'(db_init);
    else if (db_step) begin
      if (t) e_exit = 1;
      else begin
        m_cnt = (m_cnt + 65535) % 65536;
        if (m_cnt == 65535) e_exit = 1; else e_branch = 1;
      end
    end
  endtask

  task automatic clear_strobes();
    alu_valid = 0; wr_en = 0; cond_valid = 0; db_load = 0; db_step = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("ccr", ccr, m_pack());
    chk("db_count", db_count, m_cnt);
    chk("cond_done", cond_done, e_done);
    chk("db_branch", db_branch, e_branch);
    chk("db_exit", db_exit, e_exit);
    if (e_done) chk("cond_true", cond_true, e_true);
    clear_strobes();
  endtask

  task automatic alu(input bit c, input bit z, input bit v, input bit n, input logic [4:0] m, input bit s);
    alu_valid = 1; alu_c = c; alu_z = z; alu_v = v; alu_n = n; upd_mask = m; z_sticky = s;
  endtask

  task automatic wr(input logic [1:0] op, input logic [4:0] d);
    wr_en = 1; wr_op = op; wr_data = d;
  endtask

  task automatic evalc(input logic [3:0] c);
    cond_valid = 1; cond = c;
  endtask

  initial begin
    clear_strobes();
    alu_c = 0; alu_z = 0; alu_v = 0; alu_n = 0; upd_mask = 0; z_sticky = 0;
    wr_op = 0; wr_data = 0; cond = 0; db_init = 0;
    reset = 1;
    model_reset();
    #12;
    chk("rst_ccr", ccr, 5'b00000);
    chk("rst_cnt", db_count, 0);
    chk("rst_pulses", {cond_true, cond_done, db_branch, db_exit}, 4'b0000);
    reset = 0;

    evalc(4'd7); cyc(); chk("eq_after_rst", cond_true, 1'b0);
    evalc(4'd0); cyc(); chk("t_after_rst", cond_true, 1'b1);

    alu(1, 1, 0, 0, 5'b11111, 0); cyc(); chk("ffff_plus_1", ccr, 5'b10101);
    evalc(4'd7); cyc(); chk("eq_set", cond_true, 1'b1);
    evalc(4'd2); cyc(); chk("hi_clr", cond_true, 1'b0);

    alu(0, 0, 1, 1, 5'b11111, 0); cyc(); chk("7fff_plus_1", ccr, 5'b01010);
    evalc(4'hC); cyc(); chk("ge", cond_true, 1'b1);
    evalc(4'hD); cyc(); chk("lt", cond_true, 1'b0);
    evalc(4'hF); cyc(); chk("le", cond_true, 1'b0);

    wr(2'b00, 5'b10101); cyc();
    alu(1, 0, 1, 1, 5'b00100, 1); cyc(); chk("sticky_clear", ccr, 5'b10001);
    alu(0, 1, 0, 0, 5'b00100, 1); cyc(); chk("sticky_hold", ccr, 5'b10001);
    wr(2'b00, 5'b10101); cyc();
    wr(2'b01, 5'b01111); alu(0, 0, 1, 1, 5'b11111, 0); cyc(); chk("wr_over_alu", ccr, 5'b00101);
    wr(2'b10, 5'b01000); cyc(); chk("wr_or", ccr, 5'b01101);
    wr(2'b11, 5'b11111); cyc(); chk("wr_eor", ccr, 5'b10010);

    db_init = 16'h0002; db_load = 1; cyc(); chk("db_load", db_count, 16'h0002);
    cond = 4'd1; db_step = 1; cyc(); chk("db1", {db_count, db_branch, db_exit}, {16'h0001, 2'b10});
    cond = 4'd1; db_step = 1; cyc(); chk("db2", {db_count, db_branch, db_exit}, {16'h0000, 2'b10});
    cond = 4'd1; db_step = 1; cyc(); chk("db3", {db_count, db_branch, db_exit}, {16'hFFFF, 2'b01});
    cond = 4'd0; db_step = 1; cyc(); chk("db_true", {db_count, db_branch, db_exit}, {16'hFFFF, 2'b01});
    db_init = 16'h0005; db_load = 1; cond = 4'd1; db_step = 1; cyc();
    chk("db_load_wins", {db_count, db_branch, db_exit}, {16'h0005, 2'b00});

    wr(2'b00, 5'b00000); cyc();
    alu(0, 1, 0, 0, 5'b11111, 0); evalc(4'd7); cyc(); chk("forward", cond_true, FWD);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #3 reset = 1;
        model_reset();
        #2;
        chk("mid_rst_ccr", ccr, 5'b00000);
        chk("mid_rst_cnt", db_count, 0);
        chk("mid_rst_pulses", {cond_true, cond_done, db_branch, db_exit}, 4'b0000);
        #2 reset = 0;
      end
      alu_valid = ($urandom_range(0, 1) == 1);
      {alu_c, alu_z, alu_v, alu_n} = 4'($urandom);
      upd_mask = 5'($urandom);
      z_sticky = ($urandom_range(0, 2) == 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wr_op = 2'($urandom);
      wr_data = 5'($urandom);
      cond = 4'($urandom);
      cond_valid = ($urandom_range(0, 1) == 1);
      db_load = ($urandom_range(0, 15) == 0);
      db_init = 16'($urandom_range(0, 4));
      db_step = ($urandom_range(0, 1) == 1);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
